// File: rtl/qpix_seq_pkg.sv
// Shared widths and FSM state encodings for the QPix window sequencer.
package qpix_seq_pkg;
    localparam int WIN_W  = 32;
    localparam int CNT_W  = 16;
    localparam int NWIN_W = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RESET  = 3'd1;
    localparam logic [2:0] ST_GAP    = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_WINDOW = 3'd4;
endpackage

// File: rtl/qpix_rise_detect.sv
// Registered rising-edge detector: rise is high in the cycle d first reads 1.
module qpix_rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);
    logic d_q;

    always_ff @(posedge clk) begin
        if (rst) d_q <= 1'b0;
        else     d_q <= d;
    end

    assign rise = d & ~d_q;
endmodule

// File: rtl/qpix_window_sequencer.sv
// Timed ASIC reset / calibration gap / settle / sample-window sequencer that gates FIFO writes.
// Handshake: none; seq_en is a level, a registered rise (after being seen low) starts a run.
module qpix_window_sequencer
    import qpix_seq_pkg::*;
#(
    parameter int WIN_W_P  = WIN_W,
    parameter int CNT_W_P  = CNT_W,
    parameter int NWIN_W_P = NWIN_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                seq_en,
    input  logic [WIN_W_P-1:0]  window_width,
    input  logic [CNT_W_P-1:0]  reset_width,
    input  logic [CNT_W_P-1:0]  cal_gap,
    input  logic [CNT_W_P-1:0]  window_wait,
    input  logic                sel_window,
    input  logic                trig_manual,
    output logic                rst_ext,
    output logic                window_valid,
    output logic                gate_out,
    output logic                busy,
    output logic                win_done,
    output logic [NWIN_W_P-1:0] n_windows,
    output logic [2:0]          state_dbg
);
    localparam logic [WIN_W_P-1:0]  ONE_W = 1;
    localparam logic [NWIN_W_P-1:0] ONE_N = 1;

    logic [2:0]          state_q, state_n;
    logic [WIN_W_P-1:0]  cnt_q, cnt_n;
    logic [WIN_W_P-1:0]  sh_ww, src_ww;
    logic [CNT_W_P-1:0]  sh_rw, sh_gap, sh_wait, src_rw, src_gap, src_wait;
    logic [NWIN_W_P-1:0] n_base, n_next;
    logic                en_rise, armed, start, capture, valid_n, done_n;
    logic                go_reset, go_gap, go_wait, go_win;

    qpix_rise_detect u_en_rise (.clk(clk), .rst(rst), .d(seq_en), .rise(en_rise));

    // A reset clears armed so a seq_en left high through rst cannot restart the run.
    assign start     = en_rise & armed & (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign state_dbg = state_q;

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        valid_n  = 1'b0;
        capture  = 1'b0;
        go_reset = 1'b0;
        go_gap   = 1'b0;
        go_wait  = 1'b0;
        go_win   = 1'b0;
        case (state_q)
            ST_IDLE:   if (start) begin capture = 1'b1; go_reset = 1'b1; end
            ST_RESET:  if (cnt_q == '0) go_gap  = 1'b1; else cnt_n = cnt_q - ONE_W;
            ST_GAP:    if (cnt_q == '0) go_wait = 1'b1; else cnt_n = cnt_q - ONE_W;
            ST_WAIT:   if (cnt_q == '0) go_win  = 1'b1; else cnt_n = cnt_q - ONE_W;
            ST_WINDOW: begin
                if (cnt_q != '0) begin
                    cnt_n   = cnt_q - ONE_W;
                    valid_n = 1'b1;
                end else if (seq_en) begin
                    capture  = 1'b1;
                    go_reset = 1'b1;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            default:   state_n = ST_IDLE;
        endcase

        src_rw   = capture ? reset_width  : sh_rw;
        src_gap  = capture ? cal_gap      : sh_gap;
        src_wait = capture ? window_wait  : sh_wait;
        src_ww   = capture ? window_width : sh_ww;

        // Zero-length states fall through in the same cycle; WINDOW always takes one.
        if (go_reset) begin
            if (src_rw != '0) begin state_n = ST_RESET; cnt_n = WIN_W_P'(src_rw) - ONE_W; end
            else go_gap = 1'b1;
        end
        if (go_gap) begin
            if (src_gap != '0) begin state_n = ST_GAP; cnt_n = WIN_W_P'(src_gap) - ONE_W; end
            else go_wait = 1'b1;
        end
        if (go_wait) begin
            if (src_wait != '0) begin state_n = ST_WAIT; cnt_n = WIN_W_P'(src_wait) - ONE_W; end
            else go_win = 1'b1;
        end
        if (go_win) begin
            state_n = ST_WINDOW;
            cnt_n   = (src_ww != '0) ? src_ww - ONE_W : '0;
            valid_n = (src_ww != '0);
        end

        if ((state_q != ST_IDLE) && !seq_en) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            valid_n = 1'b0;
        end

        done_n = (state_n == ST_WINDOW) && (cnt_n == '0);
        n_base = start ? '0 : n_windows;
        n_next = (done_n && (n_base != '1)) ? n_base + ONE_N : n_base;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            sh_ww        <= '0;
            sh_rw        <= '0;
            sh_gap       <= '0;
            sh_wait      <= '0;
            armed        <= 1'b0;
            rst_ext      <= 1'b0;
            window_valid <= 1'b0;
            gate_out     <= 1'b0;
            win_done     <= 1'b0;
            n_windows    <= '0;
        end else begin
            state_q      <= state_n;
            cnt_q        <= cnt_n;
            if (!seq_en) armed <= 1'b1;
            if (capture) begin
                sh_ww   <= window_width;
                sh_rw   <= reset_width;
                sh_gap  <= cal_gap;
                sh_wait <= window_wait;
            end
            rst_ext      <= (state_n == ST_RESET);
            window_valid <= valid_n;
            gate_out     <= sel_window ? valid_n : trig_manual;
            win_done     <= done_n;
            n_windows    <= n_next;
        end
    end
endmodule

// File: tb/tb_qpix_window_sequencer.sv
// Directed bench for qpix_window_sequencer with hand-computed cycle positions.
module tb_qpix_window_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seq_en = 1'b0;
    logic [31:0] window_width = '0;
    logic [15:0] reset_width = '0, cal_gap = '0, window_wait = '0;
    logic        sel_window = 1'b1;
    logic        trig_manual = 1'b0;
    logic        rst_ext, window_valid, gate_out, busy, win_done;
    logic [15:0] n_windows;
    logic [2:0]  state_dbg;

    int checks = 0;
    int failures = 0;

    // per-run statistics gathered by tick
    int cyc, n_rst, rst_first, rst_last, n_wv, wv_first, wv_last, gate_mis;
    int done_q[$];
    int nw_q[$];

    qpix_window_sequencer dut (
        .clk(clk), .rst(rst), .seq_en(seq_en), .window_width(window_width),
        .reset_width(reset_width), .cal_gap(cal_gap), .window_wait(window_wait),
        .sel_window(sel_window), .trig_manual(trig_manual), .rst_ext(rst_ext),
        .window_valid(window_valid), .gate_out(gate_out), .busy(busy),
        .win_done(win_done), .n_windows(n_windows), .state_dbg(state_dbg)
    );

    always #10 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        cyc = 0; n_rst = 0; rst_first = -1; rst_last = -1;
        n_wv = 0; wv_first = -1; wv_last = -1; gate_mis = 0;
        done_q.delete(); nw_q.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (rst_ext) begin
            n_rst++;
            if (rst_first < 0) rst_first = cyc;
            rst_last = cyc;
        end
        if (window_valid) begin
            n_wv++;
            if (wv_first < 0) wv_first = cyc;
            wv_last = cyc;
        end
        if (win_done) begin
            done_q.push_back(cyc);
            nw_q.push_back(int'(n_windows));
        end
        if (sel_window && (gate_out != window_valid)) gate_mis++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_len(input int rw, input int gap, input int wt, input int ww);
        reset_width = 16'(rw); cal_gap = 16'(gap); window_wait = 16'(wt); window_width = 32'(ww);
    endtask

    task automatic check_done(input string tag, input int idx, input int c, input int nw);
        check({tag, "_done_count_ge"}, (done_q.size() > idx) ? 32'd1 : 32'd0, 32'd1);
        if (done_q.size() > idx) begin
            check({tag, "_done_cycle"}, 32'(done_q[idx]), 32'(c));
            check({tag, "_done_nwin"}, 32'(nw_q[idx]), 32'(nw));
        end
    endtask

    initial begin
        // 1: reset and idle
        ticks(3);
        check("rst_rst_ext", 32'(rst_ext), 0);
        check("rst_window_valid", 32'(window_valid), 0);
        check("rst_gate_out", 32'(gate_out), 0);
        check("rst_win_done", 32'(win_done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_n_windows", 32'(n_windows), 0);
        rst = 1'b0;
        clear_stats();
        ticks(20);
        check("idle_busy", 32'(busy), 0);
        check("idle_rst_pulses", 32'(n_rst), 0);
        check("idle_done_pulses", 32'(done_q.size()), 0);

        // 2: 250/5/100/100, abort in second RESET
        set_len(250, 5, 100, 100);
        clear_stats();
        seq_en = 1'b1;
        ticks(455);
        check("t2_rst_first", 32'(rst_first), 1);
        check("t2_rst_last", 32'(rst_last), 250);
        check("t2_rst_len", 32'(n_rst), 250);
        check("t2_wv_first", 32'(wv_first), 356);
        check("t2_wv_last", 32'(wv_last), 455);
        check("t2_wv_len", 32'(n_wv), 100);
        check("t2_done_pulses", 32'(done_q.size()), 1);
        check_done("t2", 0, 455, 1);
        ticks(5);
        check("t2_second_reset", 32'(rst_ext), 1);
        check("t2_busy_before_abort", 32'(busy), 1);
        seq_en = 1'b0;
        tick();
        check("t2_abort_busy", 32'(busy), 0);
        check("t2_abort_rst_ext", 32'(rst_ext), 0);
        check("t2_abort_win_done", 32'(win_done), 0);
        check("t2_abort_n_windows", 32'(n_windows), 1);
        check("t2_gate_align", 32'(gate_mis), 0);

        // 3: continuous loop 10/2/3/4, period 19
        set_len(10, 2, 3, 4);
        clear_stats();
        seq_en = 1'b1;
        ticks(57);
        check("t3_done_pulses", 32'(done_q.size()), 3);
        check_done("t3_a", 0, 19, 1);
        check_done("t3_b", 1, 38, 2);
        check_done("t3_c", 2, 57, 3);
        check("t3_rst_total", 32'(n_rst), 30);
        check("t3_wv_total", 32'(n_wv), 12);
        tick();
        check("t3_no_idle_gap", 32'(rst_ext), 1);
        check("t3_gate_align", 32'(gate_mis), 0);
        seq_en = 1'b0;
        tick();

        // 4: zero gap/wait/window, reset 7 -> period 8
        set_len(7, 0, 0, 0);
        clear_stats();
        seq_en = 1'b1;
        ticks(24);
        check("t4_wv_total", 32'(n_wv), 0);
        check("t4_rst_total", 32'(n_rst), 21);
        check("t4_done_pulses", 32'(done_q.size()), 3);
        check_done("t4_a", 0, 8, 1);
        check_done("t4_b", 1, 16, 2);
        check_done("t4_c", 2, 24, 3);
        seq_en = 1'b0;
        tick();

        // 5: window_width change mid-window
        set_len(2, 1, 1, 100);
        clear_stats();
        seq_en = 1'b1;
        ticks(50);
        check("t5_in_window", 32'(window_valid), 1);
        window_width = 32'd50;
        ticks(108);
        check("t5_wv_first", 32'(wv_first), 5);
        check("t5_wv_last", 32'(wv_last), 158);
        check("t5_wv_total", 32'(n_wv), 150);
        check_done("t5_a", 0, 104, 1);
        check_done("t5_b", 1, 158, 2);
        check("t5_gate_align", 32'(gate_mis), 0);
        seq_en = 1'b0;
        tick();

        // 6: manual trigger gating, then rst mid-WAIT
        sel_window = 1'b0;
        set_len(3, 2, 10, 5);
        clear_stats();
        seq_en = 1'b1;
        check("t6_gate_init", 32'(gate_out), 0);
        begin
            logic [5:0] pat;
            pat = 6'b101101;
            for (int i = 0; i < 6; i++) begin
                trig_manual = pat[i];
                tick();
                check("t6_gate_follow", 32'(gate_out), 32'(pat[i]));
            end
        end
        ticks(2);
        check("t6_in_wait", 32'(busy), 1);
        trig_manual = 1'b1;
        rst = 1'b1;
        tick();
        check("t6_rst_rst_ext", 32'(rst_ext), 0);
        check("t6_rst_window_valid", 32'(window_valid), 0);
        check("t6_rst_gate_out", 32'(gate_out), 0);
        check("t6_rst_win_done", 32'(win_done), 0);
        check("t6_rst_busy", 32'(busy), 0);
        rst = 1'b0;
        ticks(5);
        check("t6_no_restart_held", 32'(busy), 0);
        seq_en = 1'b0;
        tick();
        seq_en = 1'b1;
        tick();
        check("t6_restart_rst_ext", 32'(rst_ext), 1);
        check("t6_restart_busy", 32'(busy), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
